// File: rtl/mul_controller.sv
// Control FSM for an add-and-decrement multiplier: loads A and B from the shared
// datain bus, adds A into the product once per multiplier count, then holds done until ack.
module mul_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        eqz,
  input  logic        ack,
  output logic        lda,
  output logic        ldb,
  output logic        clrp,
  output logic        ldp,
  output logic        decb,
  output logic        busy,
  output logic        done,
  output logic [15:0] iter_cnt,
  output logic [2:0]  dbg_state
);

  // Handshake: start is a level request taken only in IDLE (ignored while busy);
  // done stays high in DONE until ack is seen there, and ack anywhere else is ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] iter_cnt_q, iter_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD_A;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_CALC;
      S_CALC:   if (eqz) state_d = S_DONE;
      S_DONE:   if (ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ldp/decb and the count increment are the only outputs that look at eqz.
  always_comb begin
    lda        = 1'b0;
    ldb        = 1'b0;
    clrp       = 1'b0;
    ldp        = 1'b0;
    decb       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    iter_cnt_d = iter_cnt_q;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD_A: begin
        lda = 1'b1;
      end
      S_LOAD_B: begin
        ldb        = 1'b1;
        clrp       = 1'b1;
        iter_cnt_d = 16'd0;
      end
      S_CALC: begin
        if (!eqz) begin
          ldp        = 1'b1;
          decb       = 1'b1;
          iter_cnt_d = iter_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign iter_cnt  = iter_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_controller.sv
// Bench for mul_controller: a small datapath stand-in answers the strobes and drives eqz;
// each task runs one scenario and compares against products and latencies computed from A and B.
module tb_mul_controller;

  localparam int TIMEOUT = 400;

  logic        clk = 1'b0;
  logic        rst, start, eqz, ack;
  logic        lda, ldb, clrp, ldp, decb, busy, done;
  logic [15:0] iter_cnt;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] op_a = 16'd0, op_b = 16'd0;
  logic [15:0] reg_a = 16'd0, reg_b = 16'd0, reg_p = 16'd0;
  int lda_cnt = 0, ldb_cnt = 0, ldp_cnt = 0, decb_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mul_controller dut (
    .clk(clk), .rst(rst), .start(start), .eqz(eqz), .ack(ack),
    .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
    .busy(busy), .done(done), .iter_cnt(iter_cnt), .dbg_state(dbg_state)
  );

  // Datapath stand-in: the source presents A while lda is high and B while ldb is high.
  assign eqz = (reg_b == 16'd0);
  always @(posedge clk) begin
    if (lda)  reg_a <= op_a;
    if (ldb)  reg_b <= op_b;
    if (clrp) reg_p <= 16'd0;
    if (ldp)  reg_p <= reg_p + reg_a;
    if (decb) reg_b <= reg_b - 16'd1;
    lda_cnt  += int'(lda);
    ldb_cnt  += int'(ldb);
    ldp_cnt  += int'(ldp);
    decb_cnt += int'(decb);
  end

  // Strobe exclusivity and idle quietness hold in every cycle outside reset.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      total++;
      if (((ldp | decb) & (lda | ldb | clrp)) | (lda & ldb)) begin
        bad++; $display("FAIL strobe_excl t=%0t got lda=%b ldb=%b clrp=%b ldp=%b decb=%b want no overlap", $time, lda, ldb, clrp, ldp, decb);
      end
      total++;
      if (!busy && (lda | ldb | clrp | ldp | decb | done)) begin
        bad++; $display("FAIL idle_quiet t=%0t got strobes/done active with busy=0 want all low", $time);
      end
    end
  end

  // Called at a negedge with the FSM idle; returns at the negedge where done is first seen.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit keep_start, output int lat);
    op_a = a; op_b = b;
    lda_cnt = 0; ldb_cnt = 0; ldp_cnt = 0; decb_cnt = 0;
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      if (!keep_start) start = 1'b0;
      lat++;
    end while (done !== 1'b1 && lat < TIMEOUT);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({lda, ldb, clrp, ldp, decb, busy, done} !== 7'b0) begin bad++; $display("FAIL reset_outputs got=%b want=0000000", {lda, ldb, clrp, ldp, decb, busy, done}); end
    total++; if (iter_cnt !== 16'h0000) begin bad++; $display("FAIL reset_iter got=%h want=0000", iter_cnt); end
    start = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_over_start got busy=%b want 0", busy); end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    int lat;
    do_op(16'd7, 16'd5, 1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("FAIL normal_latency got=%0d want=9", lat); end
    total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL normal_done got done=%b busy=%b want 1 1", done, busy); end
    total++; if (reg_p !== 16'd35) begin bad++; $display("FAIL normal_result got=%0d want=35", reg_p); end
    total++; if (iter_cnt !== 16'd5) begin bad++; $display("FAIL normal_iter got=%0d want=5", iter_cnt); end
    total++; if (ldp_cnt !== 5 || decb_cnt !== 5) begin bad++; $display("FAIL normal_pulses got ldp=%0d decb=%0d want 5 5", ldp_cnt, decb_cnt); end
    total++; if (lda_cnt !== 1 || ldb_cnt !== 1) begin bad++; $display("FAIL normal_loads got lda=%0d ldb=%0d want 1 1", lda_cnt, ldb_cnt); end
    do_ack();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL normal_ack got busy=%b done=%b want 0 0", busy, done); end
    repeat (2) @(negedge clk);
    total++; if (iter_cnt !== 16'd5) begin bad++; $display("FAIL normal_iter_hold got=%0d want=5", iter_cnt); end
  endtask

  task automatic test_zero();
    int lat;
    do_op(16'h1234, 16'd0, 1'b0, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL zero_latency got=%0d want=4", lat); end
    total++; if (reg_p !== 16'd0) begin bad++; $display("FAIL zero_result got=%h want=0000", reg_p); end
    total++; if (iter_cnt !== 16'd0) begin bad++; $display("FAIL zero_iter got=%0d want=0", iter_cnt); end
    total++; if (ldp_cnt !== 0 || decb_cnt !== 0) begin bad++; $display("FAIL zero_pulses got ldp=%0d decb=%0d want 0 0", ldp_cnt, decb_cnt); end
    do_ack();
  endtask

  task automatic test_wrap();
    int lat;
    do_op(16'h8000, 16'd3, 1'b0, lat);
    total++; if (lat !== 7) begin bad++; $display("FAIL wrap_latency got=%0d want=7", lat); end
    total++; if (reg_p !== 16'h8000) begin bad++; $display("FAIL wrap_result got=%h want=8000", reg_p); end
    total++; if (iter_cnt !== 16'd3) begin bad++; $display("FAIL wrap_iter got=%0d want=3", iter_cnt); end
    do_ack();
  endtask

  task automatic test_random();
    int lat, wait_n;
    logic [15:0] a, b, exp;
    logic [31:0] full;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 24));
      full = 32'(a) * 32'(b);
      exp_q.push_back(full[15:0]);
      do_op(a, b, 1'b0, lat);
      total++; if (lat !== 4 + int'(b)) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, 4 + int'(b)); end
      total++; if (iter_cnt !== b) begin bad++; $display("FAIL rand_iter[%0d] got=%0d want=%0d", i, iter_cnt, b); end
      total++; if (ldp_cnt !== int'(b)) begin bad++; $display("FAIL rand_ldp[%0d] got=%0d want=%0d", i, ldp_cnt, b); end
      wait_n = $urandom_range(0, 3);
      repeat (wait_n) @(negedge clk);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL rand_done[%0d] got=%b want=1", i, done); end
      exp = exp_q.pop_front();
      total++; if (reg_p !== exp) begin bad++; $display("FAIL rand_result[%0d] a=%h b=%0d got=%h want=%h", i, a, b, reg_p, exp); end
      do_ack();
    end
  endtask

  task automatic test_ignored();
    int lat;
    do_op(16'd9, 16'd6, 1'b1, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL held_start_latency got=%0d want=10", lat); end
    total++; if (lda_cnt !== 1 || ldb_cnt !== 1) begin bad++; $display("FAIL held_start_loads got lda=%0d ldb=%0d want 1 1", lda_cnt, ldb_cnt); end
    total++; if (reg_p !== 16'd54) begin bad++; $display("FAIL held_start_result got=%0d want=54", reg_p); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ack_start_idle got busy=%b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0 || lda_cnt !== 1) begin bad++; $display("FAIL ack_start_no_restart[%0d] got busy=%b lda=%0d want 0 1", i, busy, lda_cnt); end
    end
    do_op(16'd2, 16'd3, 1'b0, lat);
    total++; if (lat !== 7 || reg_p !== 16'd6) begin bad++; $display("FAIL restart_op got lat=%0d p=%0d want 7 6", lat, reg_p); end
    do_ack();
  endtask

  task automatic test_ack_ignored();
    int lat;
    ack = 1'b1;
    do_op(16'd5, 16'd4, 1'b0, lat);
    ack = 1'b0;
    total++; if (lat !== 8) begin bad++; $display("FAIL early_ack_latency got=%0d want=8", lat); end
    @(negedge clk);
    total++; if (done !== 1'b1 || reg_p !== 16'd20) begin bad++; $display("FAIL early_ack_done got done=%b p=%0d want 1 20", done, reg_p); end
    do_ack();
  endtask

  task automatic test_reset_mid_calc();
    int calc_seen, guard, lat;
    op_a = 16'd3; op_b = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    calc_seen = 0; guard = 0;
    while (calc_seen < 10 && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
      if (ldp === 1'b1) calc_seen++;
    end
    total++; if (calc_seen !== 10) begin bad++; $display("FAIL midcalc_reach got=%0d want=10", calc_seen); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midcalc_reset got busy=%b done=%b want 0 0", busy, done); end
    total++; if (iter_cnt !== 16'd0) begin bad++; $display("FAIL midcalc_iter got=%0d want=0", iter_cnt); end
    total++; if ({lda, ldb, clrp, ldp, decb} !== 5'b0) begin bad++; $display("FAIL midcalc_strobes got=%b want=00000", {lda, ldb, clrp, ldp, decb}); end
    rst = 1'b0;
    @(negedge clk);
    do_op(16'd4, 16'd4, 1'b0, lat);
    total++; if (reg_p !== 16'd16 || iter_cnt !== 16'd4) begin bad++; $display("FAIL after_reset_op got p=%0d iter=%0d want 16 4", reg_p, iter_cnt); end
    total++; if (lat !== 8) begin bad++; $display("FAIL after_reset_latency got=%0d want=8", lat); end
    do_ack();
  endtask

  task automatic test_done_hold();
    int lat;
    do_op(16'h00FF, 16'd7, 1'b0, lat);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL hold_done[%0d] got done=%b busy=%b want 1 1", i, done, busy); end
      total++; if ({lda, ldb, clrp, ldp, decb} !== 5'b0) begin bad++; $display("FAIL hold_strobes[%0d] got=%b want=00000", i, {lda, ldb, clrp, ldp, decb}); end
      total++; if (reg_p !== 16'h06F9) begin bad++; $display("FAIL hold_result[%0d] got=%h want=06f9", i, reg_p); end
    end
    do_ack();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_release got done=%b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero();
    test_wrap();
    test_random();
    test_ignored();
    test_ack_ignored();
    test_reset_mid_calc();
    test_done_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_controller.md
MUL_CONTROLLER -- requirements
Module: mul_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request a new multiplication; sampled only in IDLE.
REQ-005 eqz  input  1  datapath flag, high when the multiplier counter equals 0.
REQ-006 ack  input  1  consumer acknowledge of the product; sampled only in DONE.
REQ-007 lda  output  1  load multiplicand register from datain.
REQ-008 ldb  output  1  load multiplier counter from datain.
REQ-009 clrp  output  1  clear product register.
REQ-010 ldp  output  1  load product register with product+multiplicand.
REQ-011 decb  output  1  decrement multiplier counter.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  product valid on the datapath result bus.
REQ-014 iter_cnt  output  16  number of additions performed in the current or most recent operation.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, LOAD_A, LOAD_B, CALC and DONE.
REQ-016 IDLE: all strobes low, done low, busy low; start=1 -> LOAD_A; otherwise stay in IDLE.
REQ-017 LOAD_A: lda=1 for one cycle; the source holds the multiplicand on datain; the next state SHALL be LOAD_B.
REQ-018 LOAD_B: ldb=1 and clrp=1 for one cycle; the source holds the multiplier on datain; iter_cnt SHALL be cleared to 0; the next state SHALL be CALC.
REQ-019 CALC with eqz=0: ldp=1, decb=1, iter_cnt increments by 1 (16-bit, wraps at 0xFFFF to 0x0000); the FSM stays in CALC.
REQ-020 CALC with eqz=1: all strobes low; the next state SHALL be DONE.
REQ-021 DONE: done=1, busy=1, all strobes low; ack=1 -> IDLE; otherwise hold DONE with done high indefinitely.
REQ-022 All outputs SHALL be Moore outputs decoded from the state register, except ldp, decb and the iter_cnt increment, which also depend on eqz in CALC.
REQ-023 Latency: with start accepted at edge T0, done SHALL rise after edge T0+4+B, where B is the multiplier value; B=0 gives done after T0+4 with iter_cnt=0.
REQ-024 The resulting product on the datapath SHALL equal (A*B) mod 2^16; overflow is not flagged.
REQ-025 start asserted while busy=1 SHALL be ignored; there is no queuing.
REQ-026 If ack and start are both high in DONE, the FSM SHALL return to IDLE and start SHALL be ignored; start must be re-presented in IDLE.
REQ-027 ack outside DONE SHALL be ignored.
REQ-028 ldp/decb and lda/ldb/clrp SHALL never be high in the same cycle.
REQ-029 At most one of lda and ldb SHALL be high in any cycle.
REQ-030 iter_cnt SHALL hold its value through DONE and IDLE until the next LOAD_B.

Reset
REQ-031 rst=1 SHALL force IDLE on the next edge from any state, including mid-CALC, and takes priority over start and ack.
REQ-032 After reset: lda=ldb=clrp=ldp=decb=0, busy=0, done=0, iter_cnt=0x0000.
REQ-033 The datapath registers are not reset by this block; the next operation SHALL reinitialise them through LOAD_A and LOAD_B.

Verification
REQ-034 Normal multiply: A=7, B=5, start pulse, then ack when done -> done rises 9 cycles after start acceptance; result=35, iter_cnt=5.
REQ-035 Zero multiplier: A=0x1234, B=0 -> no ldp or decb pulses; done after 4 cycles; result=0, iter_cnt=0.
REQ-036 Wrap: A=0x8000, B=3 -> result=0x8000 (mod 2^16); iter_cnt=3.
REQ-037 Ignored requests: start held high throughout the operation -> exactly one LOAD_A/LOAD_B sequence; start ignored while busy; with ack and start both high in DONE -> IDLE, and a new operation begins only on the following start.
REQ-038 Reset mid-CALC: A=3, B=100, rst asserted at the 10th CALC cycle -> IDLE next edge, busy=0, done=0, iter_cnt=0; a subsequent A=4, B=4 operation -> result=16.
REQ-039 Done hold: ack withheld for 20 cycles -> done stays high, strobes stay low, and result is stable throughout.
